truth_table_sweeper: RTL and testbench

Sequential characterizer for combinational truth-table logic blocks (the 3-input case-statement gates). It drives every input combination into a device under test (DUT) and waits for the response to settle. It then samples the single-bit response and assembles the observed truth table in the same hex-naming order the gate modules use. An optional expected table gives a pass/fail flag and the index of the first failing row. It is used in lab and bench flows to read a gate's function back.

---
 rtl/truth_table_sweeper_pkg.sv | 32 +++
 rtl/truth_table_sweeper_resp_sync.sv | 44 ++++
 rtl/truth_table_sweeper.sv | 159 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_pkg
// Description : Shared types and sizing helpers for the truth-table sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_sweeper_pkg;

    // Sweep controller states; the done pulse is not a state of its own.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    // Number of rows in a truth table of n_in inputs.
    function automatic int rows_f(input int n_in);
        return 2 ** n_in;
    endfunction

    // Cycles each stimulus value is held: settle time, synchronizer depth,
    // plus the capture cycle itself.
    function automatic int win_f(input int settle, input int sync_stages);
        return settle + sync_stages + 1;
    endfunction

    // Bits needed to count from 0 up to max_val inclusive.
    function automatic int cnt_width_f(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : truth_table_sweeper_pkg
`default_nettype wire

// File: rtl/truth_table_sweeper_resp_sync.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_resp_sync
// Description : SYNC_STAGES-deep flop chain bringing the (possibly
//               asynchronous) DUT response into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper_resp_sync #(
    parameter int SYNC_STAGES = 2   // must be at least 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            // Single flop: sample the response directly.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= d_i;
                end
            end
        end else begin : g_chain
            // Shift the response through the chain, entering at bit 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
                end
            end
        end
    endgenerate

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule : truth_table_sweeper_resp_sync
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives every input combination into a combinational DUT,
//               samples its synchronized response after a settle window and
//               assembles the observed truth table (row k at bit ROWS-1-k),
//               comparing it against a reference captured at start.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [(2**N_IN)-1:0]   expected_i,
    input  logic                   resp_i,
    output logic [N_IN-1:0]        stim_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [(2**N_IN)-1:0]   table_out_o,
    output logic                   mismatch_o,
    output logic [N_IN-1:0]        first_fail_o
);

    localparam int ROWS = rows_f(N_IN);
    localparam int W    = win_f(SETTLE, SYNC_STAGES);
    localparam int CW   = cnt_width_f(W - 1);

    localparam logic [CW-1:0]   C_CNT_LAST = CW'(W - 1);
    localparam logic [N_IN-1:0] C_ROW_LAST = N_IN'(ROWS - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   row_q, row_d;
    logic              done_q, done_d;
    logic [ROWS-1:0]   exp_q, exp_d;
    logic [ROWS-1:0]   shadow_q, shadow_d;
    logic [ROWS-1:0]   table_q, table_d;
    logic              mismatch_q, mismatch_d;
    logic [N_IN-1:0]   first_fail_q, first_fail_d;

    logic              resp_sync;
    logic [ROWS-1:0]   shadow_cap;
    logic [ROWS-1:0]   diff;
    logic [N_IN-1:0]   lowest_fail;

    truth_table_sweeper_resp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_resp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (resp_i),
        .q_o   (resp_sync)
    );

    // Shadow table with the current row's sample merged in; ROWS-1-row is
    // simply the bitwise complement of row for an N_IN-bit row index.
    always_comb begin
        shadow_cap         = shadow_q;
        shadow_cap[~row_q] = resp_sync;
    end

    assign diff = shadow_cap ^ exp_q;

    // Lowest failing stimulus index; scanning downward lets the smallest win.
    always_comb begin
        lowest_fail = '0;
        for (int k = ROWS - 1; k >= 0; k--) begin
            if (diff[~N_IN'(k)]) begin
                lowest_fail = N_IN'(k);
            end
        end
    end

    // Next-state logic: accept start in IDLE, step rows and capture in SWEEP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        done_d       = 1'b0;
        exp_d        = exp_q;
        shadow_d     = shadow_q;
        table_d      = table_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = SWEEP;
                    cnt_d    = '0;
                    row_d    = '0;
                    exp_d    = expected_i;
                    shadow_d = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d    = '0;
                    shadow_d = shadow_cap;
                    if (row_q == C_ROW_LAST) begin
                        // Final capture: publish results and fall back to IDLE.
                        table_d      = shadow_cap;
                        mismatch_d   = |diff;
                        first_fail_d = lowest_fail;
                        done_d       = 1'b1;
                        row_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            done_q       <= 1'b0;
            exp_q        <= '0;
            shadow_q     <= '0;
            table_q      <= '0;
            mismatch_q   <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            done_q       <= done_d;
            exp_q        <= exp_d;
            shadow_q     <= shadow_d;
            table_q      <= table_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
        end
    end

    // The row index doubles as the stimulus; it rests at 0 outside a sweep.
    assign stim_o       = row_q;
    assign busy_o       = (state_q == SWEEP);
    assign done_o       = done_q;
    assign table_out_o  = table_q;
    assign mismatch_o   = mismatch_q;
    assign first_fail_o = first_fail_q;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench for truth_table_sweeper. Two instances:
//               default settle (W=7) and zero settle (W=3), both fed from
//               behavioural DUT models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       resp0, resp1;

    logic [2:0] stim0, stim1, ff0, ff1;
    logic       busy0, busy1, done0, done1, mis0, mis1;
    logic [7:0] table0, table1;

    int n_tests = 0;
    int n_fail  = 0;

    // Response source for instance 0: 0 = ~in1, 1 = (stim==5),
    // 2 = ~in1 delayed 3 cycles, 3 = bench-driven asynchronous pattern.
    int         mode = 0;
    logic       r_async = 1'b0;
    logic [7:0] async_pat = 8'h00;
    logic [2:0] dl0 = 3'b000;
    logic [2:0] dl1 = 3'b000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dl0 <= {dl0[1:0], ~stim0[2]};
        dl1 <= {dl1[1:0], ~stim1[2]};
    end

    always_comb begin
        case (mode)
            0:       resp0 = ~stim0[2];
            1:       resp0 = (stim0 == 3'd5);
            2:       resp0 = dl0[2];
            default: resp0 = r_async;
        endcase
    end
    assign resp1 = dl1[2];

    truth_table_sweeper #(.N_IN(3), .SETTLE(4), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .expected_i(expected),
        .resp_i(resp0), .stim_o(stim0), .busy_o(busy0), .done_o(done0),
        .table_out_o(table0), .mismatch_o(mis0), .first_fail_o(ff0)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(0), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .expected_i(expected),
        .resp_i(resp1), .stim_o(stim1), .busy_o(busy1), .done_o(done1),
        .table_out_o(table1), .mismatch_o(mis1), .first_fail_o(ff1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Time is counted in edges since the accepting
    // edge e0. Row k occupies edges [k*W, (k+1)*W); its response is the
    // resp level seen SYNC_STAGES(=2) edges before the capture edge.
    // ------------------------------------------------------------------
    int       W_OF [2] = '{7, 3};
    bit       m_busy [2];
    int       m_t    [2];
    bit [7:0] m_exp  [2];
    bit [7:0] m_obs  [2];
    bit [7:0] m_tbl  [2];
    bit       m_mis  [2];
    bit       m_done [2];
    bit [2:0] m_stim [2];
    bit [2:0] m_ff   [2];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    m_busy[d] = 0; m_t[d] = 0; m_exp[d] = 0; m_obs[d] = 0;
                    m_tbl[d] = 0; m_mis[d] = 0; m_done[d] = 0; m_stim[d] = 0; m_ff[d] = 0;
                end else begin
                    m_done[d] = 0;
                    if (!m_busy[d]) begin
                        if (start) begin
                            m_busy[d] = 1; m_t[d] = 0; m_exp[d] = expected;
                            m_obs[d] = 0; m_stim[d] = 0;
                        end
                    end else begin
                        m_t[d]++;
                        if (m_t[d] % W_OF[d] == W_OF[d] - 2)
                            m_obs[d][7 - m_t[d] / W_OF[d]] = (d == 0) ? resp0 : resp1;
                        if (m_t[d] == 8 * W_OF[d]) begin
                            m_tbl[d] = m_obs[d];
                            m_mis[d] = (m_obs[d] != m_exp[d]);
                            m_ff[d]  = 0;
                            for (int k = 7; k >= 0; k--)
                                if (m_obs[d][7 - k] != m_exp[d][7 - k]) m_ff[d] = 3'(k);
                            m_busy[d] = 0; m_stim[d] = 0; m_done[d] = 1;
                        end else begin
                            m_stim[d] = 3'(m_t[d] / W_OF[d]);
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("d0.stim",  32'(stim0),  32'(m_stim[0]));
        check("d0.busy",  32'(busy0),  32'(m_busy[0]));
        check("d0.done",  32'(done0),  32'(m_done[0]));
        check("d0.table", 32'(table0), 32'(m_tbl[0]));
        check("d0.mis",   32'(mis0),   32'(m_mis[0]));
        check("d0.ff",    32'(ff0),    32'(m_ff[0]));
        check("d1.stim",  32'(stim1),  32'(m_stim[1]));
        check("d1.busy",  32'(busy1),  32'(m_busy[1]));
        check("d1.done",  32'(done1),  32'(m_done[1]));
        check("d1.table", 32'(table1), 32'(m_tbl[1]));
        check("d1.mis",   32'(mis1),   32'(m_mis[1]));
        check("d1.ff",    32'(ff1),    32'(m_ff[1]));
    end

    // One sweep on instance 0: lat = edges from e0 to the done pulse,
    // bcnt = sampled cycles with busy high. Called at a negedge.
    task automatic sweep(input logic [7:0] exp_tbl, output int lat, output int bcnt);
        expected = exp_tbl;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bcnt = busy0 ? 1 : 0;
        while (!done0 && lat < 200) begin
            @(posedge clk);
            lat++;
            if (mode == 3 && lat < 56 && lat % 7 == 1) begin
                #2 r_async = 1'bx;
            end
            if (mode == 3 && lat < 56 && lat % 7 == 3) begin
                #2 r_async = async_pat[7 - lat / 7];
            end
            @(negedge clk);
            if (busy0) bcnt++;
        end
    endtask

    int lat, bcnt, ndone, first_done;
    int dtimes [$];

    initial begin
        repeat (3) @(negedge clk);
        // Reset state
        check("rst.table", 32'(table0), 32'h00);
        check("rst.busy",  32'(busy0),  32'h0);
        check("rst.stim",  32'(stim0),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: inverter on in1
        mode = 0;
        sweep(8'hF0, lat, bcnt);
        check("t1.lat",   32'(lat),    32'd56);
        check("t1.busy",  32'(bcnt),   32'd56);
        check("t1.table", 32'(table0), 32'hF0);
        check("t1.mis",   32'(mis0),   32'h0);
        check("t1.ff",    32'(ff0),    32'h0);

        // 2: single-minterm gate, matching then failing reference
        mode = 1;
        sweep(8'h04, lat, bcnt);
        check("t2a.table", 32'(table0), 32'h04);
        check("t2a.mis",   32'(mis0),   32'h0);
        sweep(8'h00, lat, bcnt);
        check("t2b.table", 32'(table0), 32'h04);
        check("t2b.mis",   32'(mis0),   32'h1);
        check("t2b.ff",    32'(ff0),    32'd5);

        // 3: 3-cycle response delay; SETTLE=4 absorbs it, SETTLE=0 does not
        mode = 2;
        sweep(8'hF0, lat, bcnt);
        check("t3.table",     32'(table0), 32'hF0);
        check("t3.mis",       32'(mis0),   32'h0);
        check("t3.s0.differs", 32'(table1 != 8'hF0), 32'h1);
        check("t3.s0.table",  32'(table1), 32'hF8);
        check("t3.s0.mis",    32'(mis1),   32'h1);

        // 4a: start re-pulsed mid-sweep is ignored
        mode = 0;
        expected = 8'hF0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first_done = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) begin
                ndone++;
                if (first_done < 0) first_done = i;
            end
            start = (i == 10 || i == 30);
        end
        start = 1'b0;
        check("t4.ndone", 32'(ndone),      32'd1);
        check("t4.when",  32'(first_done), 32'd56);

        // 4b: start held high gives back-to-back sweeps
        start = 1'b1;
        for (int i = 0; i < 180; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) dtimes.push_back(i);
        end
        start = 1'b0;
        check("t4.held.n", 32'(dtimes.size()), 32'd3);
        if (dtimes.size() >= 3) begin
            check("t4.held.first", 32'(dtimes[0]), 32'd56);
            check("t4.held.p1",    32'(dtimes[1] - dtimes[0]), 32'd57);
            check("t4.held.p2",    32'(dtimes[2] - dtimes[1]), 32'd57);
        end
        for (int i = 0; i < 100 && busy0; i++) @(negedge clk);
        check("t4.idle", 32'(busy0), 32'h0);

        // 5: asynchronous reset during row 4
        mode = 0;
        expected = 8'hF0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("t5.pre.stim", 32'(stim0), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("t5.stim",  32'(stim0),  32'h0);
        check("t5.busy",  32'(busy0),  32'h0);
        check("t5.done",  32'(done0),  32'h0);
        check("t5.table", 32'(table0), 32'h00);
        check("t5.mis",   32'(mis0),   32'h0);
        check("t5.ff",    32'(ff0),    32'h0);
        check("t5.table1", 32'(table1), 32'h00);
        @(negedge clk);
        check("t5.hold.done", 32'(done0), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(8'hF0, lat, bcnt);
        check("t5.lat",   32'(lat),    32'd56);
        check("t5.table", 32'(table0), 32'hF0);

        // 6: asynchronously driven response, stable before each sample point
        mode = 3;
        async_pat = 8'hA5;
        sweep(8'hA5, lat, bcnt);
        check("t6a.table", 32'(table0), 32'hA5);
        check("t6a.mis",   32'(mis0),   32'h0);
        check("t6a.nox",   32'($isunknown({table0, mis0, ff0})), 32'h0);
        async_pat = 8'h3C;
        sweep(8'h3D, lat, bcnt);
        check("t6b.table", 32'(table0), 32'h3C);
        check("t6b.mis",   32'(mis0),   32'h1);
        check("t6b.ff",    32'(ff0),    32'd7);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_truth_table_sweeper
`default_nettype wire
